// File: rtl/cache_evict_fill_seq.sv
// cache_evict_fill_seq: miss sequencer that runs after the replacement policy
// has picked a victim way. It writes the victim line back if it is dirty,
// fetches the missing line in bus beats, commits it to the victim way and
// pulses the replacement-state update.
//
// Optional build macro CACHE_CRITWORD_EN: the fill starts at the beat that
// holds the missing word, wraps around the line, and adds the CritWordValid
// output. When the macro is undefined the fill always starts at beat 0.
module cache_evict_fill_seq #(
   parameter int NUMWAYS = 4,
   parameter int LINELEN = 256,
   parameter int BEATW   = 64,
   parameter int PAWIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               Miss,
   input  logic               FlushStage,
   input  logic [PAWIDTH-1:0] MissAdr,
   input  logic [NUMWAYS-1:0] VictimWay,
   input  logic               VictimDirty,
   input  logic [PAWIDTH-1:0] VictimAdr,
   input  logic [LINELEN-1:0] VictimLine,
   output logic               BusReq,
   output logic               BusWrite,
   output logic [PAWIDTH-1:0] BusAdr,
   output logic [BEATW-1:0]   BusWData,
   input  logic               BusAck,
   input  logic [BEATW-1:0]   BusRData,
   output logic [NUMWAYS-1:0] FillWay,
   output logic [LINELEN-1:0] FillLine,
   output logic               FillWrite,
   output logic               LRUWriteEn,
   output logic               SetValid,
`ifdef CACHE_CRITWORD_EN
   output logic               CritWordValid,
`endif
   output logic               Busy,
   output logic               Done
);

   localparam int BEATS    = LINELEN / BEATW;
   localparam int BEATCNTW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BYTEOFF  = $clog2(LINELEN / 8);
   localparam int BEATOFF  = $clog2(BEATW / 8);
   localparam logic [PAWIDTH-1:0]  BEATBYTES = PAWIDTH'(BEATW / 8);
   localparam logic [BEATCNTW-1:0] LASTBEAT  = BEATCNTW'(BEATS - 1);

   typedef enum logic [2:0] {IDLE, WB, FILL, WRITE, DONE} state_t;

   state_t                          state, nextState;
   logic [BEATCNTW-1:0]             beatCnt;
   logic [BEATCNTW-1:0]             fillBeat;
   logic [PAWIDTH-1:0]              victimAdrLat;
   logic [PAWIDTH-1:0]              missBase;
   logic [BEATS-1:0][BEATW-1:0]     victimBeats;
   logic [BEATS-1:0][BEATW-1:0]     fillBeats;
   logic                            accept;
   logic                            lastBeat;
   logic                            beatDone;

   assign accept   = (state == IDLE) && Miss && !FlushStage;
   assign lastBeat = (beatCnt == LASTBEAT);
   assign beatDone = BusReq && BusAck;
   assign Busy     = (state != IDLE);
   assign FillLine = fillBeats;

`ifdef CACHE_CRITWORD_EN
   logic [BEATCNTW-1:0] startBeat;
   logic [BYTEOFF-1:0]  lineOff;
   logic [BEATCNTW:0]   wrapSum;

   // Line offset of the missing word, expressed in beats.
   assign lineOff = MissAdr[BYTEOFF-1:0] >> BEATOFF;

   // Fill beat position: beat counter rotated by the critical-word start, modulo BEATS.
   always_comb begin
      wrapSum  = {1'b0, beatCnt} + {1'b0, startBeat};
      fillBeat = wrapSum[BEATCNTW-1:0];
      if (wrapSum >= (BEATCNTW+1)'(BEATS))
         fillBeat = BEATCNTW'(wrapSum - (BEATCNTW+1)'(BEATS));
   end
`else
   assign fillBeat = beatCnt;
`endif

   // Request snapshot; addresses and the victim line are only ever used as latched here.
   always_ff @(posedge clk) begin
      if (accept) begin
         victimAdrLat <= VictimAdr;
         missBase     <= {MissAdr[PAWIDTH-1:BYTEOFF], BYTEOFF'(0)};
         victimBeats  <= VictimLine;
`ifdef CACHE_CRITWORD_EN
         startBeat    <= lineOff[BEATCNTW-1:0];
`endif
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Beat counter, latched way and fill-line assembly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beatCnt   <= '0;
         FillWay   <= '0;
         fillBeats <= '0;
      end else if (accept) begin
         beatCnt <= '0;
         FillWay <= VictimWay;
      end else if (beatDone) begin
         if (state == FILL)
            fillBeats[fillBeat] <= BusRData;
         beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
      end
   end

   // Next-state decode and per-state outputs; bus outputs read as zero outside WB/FILL.
   always_comb begin
      nextState  = state;
      BusReq     = 1'b0;
      BusWrite   = 1'b0;
      BusAdr     = '0;
      BusWData   = '0;
      FillWrite  = 1'b0;
      SetValid   = 1'b0;
      LRUWriteEn = 1'b0;
      Done       = 1'b0;
`ifdef CACHE_CRITWORD_EN
      CritWordValid = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (accept)
               nextState = VictimDirty ? WB : FILL;
         end
         WB: begin
            BusReq   = 1'b1;
            BusWrite = 1'b1;
            BusAdr   = victimAdrLat + PAWIDTH'(beatCnt) * BEATBYTES;
            BusWData = victimBeats[beatCnt];
            if (BusAck && lastBeat)
               nextState = FILL;
         end
         FILL: begin
            BusReq = 1'b1;
            BusAdr = missBase + PAWIDTH'(fillBeat) * BEATBYTES;
`ifdef CACHE_CRITWORD_EN
            CritWordValid = BusAck && (beatCnt == '0);
`endif
            if (BusAck && lastBeat)
               nextState = WRITE;
         end
         WRITE: begin
            FillWrite  = 1'b1;
            SetValid   = 1'b1;
            LRUWriteEn = 1'b1;
            nextState  = DONE;
         end
         DONE: begin
            Done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // A non-one-hot victim is still accepted as given; this only flags the upstream fault.
   victimOneHot: assert property (@(posedge clk) disable iff (!reset_n)
                                  accept |-> $onehot(VictimWay));

endmodule

// File: tb/tb_cache_evict_fill_seq.sv
// Randomized scoreboard bench for cache_evict_fill_seq. Stimulus pushes the
// expected bus beats and line commit; a monitor pops and compares them.
module tb_cache_evict_fill_seq;

   localparam int NUMWAYS = 4;
   localparam int LINELEN = 256;
   localparam int BEATW   = 64;
   localparam int PAWIDTH = 32;
   localparam int BEATS   = LINELEN / BEATW;
   localparam int BPB     = BEATW / 8;
   localparam int LINEB   = LINELEN / 8;
`ifdef CACHE_CRITWORD_EN
   localparam bit CRIT = 1'b1;
`else
   localparam bit CRIT = 1'b0;
`endif

   typedef struct packed {
      logic              wr;
      logic [PAWIDTH-1:0] adr;
      logic [BEATW-1:0]   data;
      logic              crit;
   } beat_t;

   typedef struct packed {
      logic [NUMWAYS-1:0] way;
      logic [LINELEN-1:0] line;
   } commit_t;

   logic               clk = 1'b0;
   logic               reset_n = 1'b1;
   logic               Miss = 1'b0;
   logic               FlushStage = 1'b0;
   logic [PAWIDTH-1:0] MissAdr = '0;
   logic [NUMWAYS-1:0] VictimWay = 4'b0001;
   logic               VictimDirty = 1'b0;
   logic [PAWIDTH-1:0] VictimAdr = '0;
   logic [LINELEN-1:0] VictimLine = '0;
   logic               BusReq, BusWrite;
   logic [PAWIDTH-1:0] BusAdr;
   logic [BEATW-1:0]   BusWData;
   logic               BusAck = 1'b0;
   logic [BEATW-1:0]   BusRData = '0;
   logic [NUMWAYS-1:0] FillWay;
   logic [LINELEN-1:0] FillLine;
   logic               FillWrite, LRUWriteEn, SetValid, Busy, Done;
`ifdef CACHE_CRITWORD_EN
   logic               CritWordValid;
`endif

   beat_t   beatQ[$];
   commit_t commitQ[$];
   int      checks = 0;
   int      errors = 0;
   int      cyc = 0;
   int      doneCount = 0;
   int      doneCyc = 0;
   int      acceptCyc = 0;
   int      fillAcks = 0;
   int      ackMode = 0;
   bit      doneDue = 1'b0;

   cache_evict_fill_seq #(
      .NUMWAYS(NUMWAYS), .LINELEN(LINELEN), .BEATW(BEATW), .PAWIDTH(PAWIDTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .Miss(Miss), .FlushStage(FlushStage),
      .MissAdr(MissAdr), .VictimWay(VictimWay), .VictimDirty(VictimDirty),
      .VictimAdr(VictimAdr), .VictimLine(VictimLine),
      .BusReq(BusReq), .BusWrite(BusWrite), .BusAdr(BusAdr), .BusWData(BusWData),
      .BusAck(BusAck), .BusRData(BusRData),
      .FillWay(FillWay), .FillLine(FillLine), .FillWrite(FillWrite),
      .LRUWriteEn(LRUWriteEn), .SetValid(SetValid),
`ifdef CACHE_CRITWORD_EN
      .CritWordValid(CritWordValid),
`endif
      .Busy(Busy), .Done(Done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [LINELEN-1:0] act, input logic [LINELEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [LINELEN-1:0] rndLine();
      logic [LINELEN-1:0] l;
      for (int i = 0; i < LINELEN / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Cycle counter.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Bus responder: ack policy per mode, fill data taken from the expected head beat.
   initial begin
      int stallCnt;
      stallCnt = 0;
      forever begin
         @(negedge clk);
         if (!BusReq) begin
            stallCnt = 0;
            BusAck = (ackMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         end else if (ackMode == 0) begin
            BusAck = 1'b1;
         end else if (ackMode == 1) begin
            BusAck = 1'($urandom_range(0, 1));
         end else if (stallCnt < 3) begin
            BusAck = 1'b0;
            stallCnt++;
         end else begin
            BusAck = 1'b1;
            stallCnt = 0;
         end
         if (beatQ.size() > 0 && !beatQ[0].wr) BusRData = beatQ[0].data;
         else BusRData = {$urandom, $urandom};
      end
   end

   // Monitor: compares bus beats, commits and Done against the scoreboard queues.
   initial forever begin
      beat_t   eb;
      commit_t ec;
      bit      expDone;
      bit      expCrit;
      @(negedge clk);
      #1;
      if (reset_n) begin
         expCrit = 1'b0;
         if (BusReq) begin
            if (beatQ.size() == 0) begin
               chk("unexpected_beat", {BusWrite, BusAdr}, '0);
            end else begin
               eb = beatQ[0];
               chk("bus_write", BusWrite, eb.wr);
               chk("bus_adr", BusAdr, eb.adr);
               if (eb.wr) chk("bus_wdata", BusWData, eb.data);
               if (BusAck) begin
                  expCrit = CRIT && !eb.wr && eb.crit;
                  if (!eb.wr) fillAcks++;
                  void'(beatQ.pop_front());
               end
            end
         end
`ifdef CACHE_CRITWORD_EN
         if (CritWordValid || expCrit) chk("crit_word_valid", CritWordValid, expCrit);
`endif
         expDone = doneDue;
         doneDue = 1'b0;
         if (FillWrite || SetValid || LRUWriteEn) begin
            chk("strobes", {FillWrite, SetValid, LRUWriteEn}, 3'b111);
            chk("beats_before_commit", beatQ.size(), 0);
            if (commitQ.size() == 0) begin
               chk("unexpected_commit", FillWrite, 1'b0);
            end else begin
               ec = commitQ.pop_front();
               chk("fill_way", FillWay, ec.way);
               chk("fill_line", FillLine, ec.line);
            end
            doneDue = 1'b1;
         end
         if (Done || expDone) chk("done_pulse", Done, expDone);
         if (Done) begin
            doneCount++;
            doneCyc = cyc;
         end
      end
   end

   // Reference model: expected beat sequence and commit for one miss, from the address rules.
   task automatic pushExpect(input bit dirty, input logic [PAWIDTH-1:0] vadr,
                             input logic [LINELEN-1:0] vline, input logic [PAWIDTH-1:0] madr,
                             input int wayIdx, input logic [LINELEN-1:0] fline);
      beat_t   b;
      commit_t c;
      int      k, idx;
      logic [PAWIDTH-1:0] base;
      if (dirty) begin
         for (int i = 0; i < BEATS; i++) begin
            b.wr = 1'b1; b.adr = vadr + PAWIDTH'(i * BPB);
            b.data = vline[i*BEATW +: BEATW]; b.crit = 1'b0;
            beatQ.push_back(b);
         end
      end
      k = CRIT ? int'(madr % LINEB) / BPB : 0;
      base = madr - (madr % LINEB);
      for (int j = 0; j < BEATS; j++) begin
         idx = (k + j) % BEATS;
         b.wr = 1'b0; b.adr = base + PAWIDTH'(idx * BPB);
         b.data = fline[idx*BEATW +: BEATW]; b.crit = (j == 0);
         beatQ.push_back(b);
      end
      c.way = NUMWAYS'(1) << wayIdx;
      c.line = fline;
      commitQ.push_back(c);
   endtask

   // Present one accepted miss, then scramble inputs and flush to prove they are ignored.
   task automatic startMiss(input bit dirty, input logic [PAWIDTH-1:0] vadr,
                            input logic [LINELEN-1:0] vline, input logic [PAWIDTH-1:0] madr,
                            input int wayIdx, input logic [LINELEN-1:0] fline);
      pushExpect(dirty, vadr, vline, madr, wayIdx, fline);
      Miss = 1'b1; FlushStage = 1'b0; VictimDirty = dirty; VictimAdr = vadr;
      VictimLine = vline; MissAdr = madr; VictimWay = NUMWAYS'(1) << wayIdx;
      acceptCyc = cyc;
      @(negedge clk);
      Miss = 1'b0;
      FlushStage = 1'($urandom_range(0, 1));
      VictimDirty = 1'($urandom_range(0, 1));
      VictimAdr = $urandom; MissAdr = $urandom; VictimLine = rndLine();
      VictimWay = NUMWAYS'(1) << $urandom_range(0, NUMWAYS - 1);
   endtask

   task automatic waitDone();
      int d0;
      d0 = doneCount;
      for (int t = 0; t < 400 && doneCount == d0; t++) @(negedge clk);
      if (doneCount == d0) chk("done_timeout", 1'b0, 1'b1);
      FlushStage = 1'b0;
      @(negedge clk);
   endtask

   task automatic runMiss(input bit dirty, input logic [PAWIDTH-1:0] vadr,
                          input logic [LINELEN-1:0] vline, input logic [PAWIDTH-1:0] madr,
                          input int wayIdx, input logic [LINELEN-1:0] fline);
      startMiss(dirty, vadr, vline, madr, wayIdx, fline);
      waitDone();
   endtask

   initial begin
      int f0;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_busreq", BusReq, 1'b0);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_strobes", {FillWrite, SetValid, LRUWriteEn, Done}, 4'b0000);
      chk("rst_fillway", FillWay, '0);
      chk("rst_fillline", FillLine, '0);
      chk("rst_busadr", BusAdr, '0);
      chk("rst_buswdata", BusWData, '0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Clean miss, ack tied high: minimum latency.
      ackMode = 0;
      runMiss(1'b0, 32'h0, '0, 32'h1000_0048, 2, rndLine());
      chk("latency_clean", doneCyc - acceptCyc, BEATS + 2);

      // Dirty victim, ack tied high.
      runMiss(1'b1, 32'h2000_0000, rndLine(), 32'h3000_0010, 1, rndLine());
      chk("latency_dirty", doneCyc - acceptCyc, 2 * BEATS + 2);

      // Stalled acks on a dirty victim.
      ackMode = 2;
      runMiss(1'b1, 32'h4000_0100, rndLine(), 32'h5000_0038, 3, rndLine());

      // Miss blocked by FlushStage.
      ackMode = 1;
      Miss = 1'b1; FlushStage = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2 chk("flush_blocks", Busy, 1'b0);
      end
      Miss = 1'b0; FlushStage = 1'b0;
      @(negedge clk);

      // Critical-word offset 0x10.
      ackMode = 0;
      runMiss(1'b0, 32'h0, '0, 32'h6000_0010, 0, rndLine());

      // Reset during fill beat 2 aborts without strobes.
      f0 = fillAcks;
      startMiss(1'b0, 32'h0, '0, 32'h7000_0000, 1, rndLine());
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         #2;
         if (fillAcks >= f0 + 2) break;
      end
      chk("reach_fill_beat2", fillAcks >= f0 + 2, 1'b1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("async_rst_busreq", BusReq, 1'b0);
      chk("async_rst_busy", Busy, 1'b0);
      beatQ.delete();
      commitQ.delete();
      doneDue = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      runMiss(1'b0, 32'h0, '0, 32'h7000_0018, 1, rndLine());

      // Randomized misses.
      for (int n = 0; n < 30; n++) begin
         ackMode = $urandom_range(0, 2);
         runMiss(1'($urandom_range(0, 1)), {$urandom, 5'b0} & 32'hFFFF_FFE0, rndLine(),
                 $urandom, $urandom_range(0, NUMWAYS - 1), rndLine());
      end

      repeat (4) @(negedge clk);
      chk("queues_drained", beatQ.size() + commitQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cache_evict_fill_seq.md
Name: cache_evict_fill_seq

Overview:
- Sequences a cache miss once the replacement policy has named a victim way.
- Latches the one-hot victim way, writes back the victim line if it is dirty, then fetches the missing line from the bus in fixed-width beats.
- Commits the assembled line into the victim way and pulses the replacement-state update.
- Sits directly downstream of the replacement-policy block (consumes VictimWay, drives LRUWriteEn/SetValid) and upstream of the cache data/tag arrays and the bus interface.

Parameters:
NUMWAYS, 4, number of ways; VictimWay/FillWay width
LINELEN, 256, cache line size in bits
BEATW, 64, bus beat width in bits; LINELEN must be a multiple of BEATW
PAWIDTH, 32, physical address width
(derived) BEATS = LINELEN/BEATW; BEATCNTW = max(1, $clog2(BEATS)); BYTEOFF = $clog2(LINELEN/8)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
Miss  in  1  miss request, sampled in IDLE only
FlushStage  in  1  suppresses acceptance of Miss in IDLE
MissAdr  in  PAWIDTH  address of the missing access
VictimWay  in  NUMWAYS  one-hot victim way from the replacement policy
VictimDirty  in  1  selected victim way holds dirty data
VictimAdr  in  PAWIDTH  line address of the victim (writeback target)
VictimLine  in  LINELEN  victim line data
BusReq  out  1  bus transaction active
BusWrite  out  1  1 = writeback beat, 0 = fill beat
BusAdr  out  PAWIDTH  beat address
BusWData  out  BEATW  writeback beat data
BusAck  in  1  current beat completes this cycle
BusRData  in  BEATW  fill beat data, valid when BusAck
FillWay  out  NUMWAYS  way being written
FillLine  out  LINELEN  assembled fill line
FillWrite  out  1  one-cycle array write strobe
LRUWriteEn  out  1  one-cycle replacement-state update strobe
SetValid  out  1  one-cycle valid-bit set strobe, coincident with FillWrite
Busy  out  1  block is not in IDLE
Done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset_n low, asynchronous):
  - State is IDLE; beat counter is 0.
  - All strobes are 0; BusReq = 0; Busy = 0.
  - FillWay, FillLine, BusAdr and BusWData are 0.
- Reset asserted mid-transaction aborts the transaction immediately. No strobes are issued.
- IDLE: on Miss & ~FlushStage, latch VictimWay, VictimDirty, VictimAdr, VictimLine, and MissAdr with its low BYTEOFF bits cleared. Next state is WB if VictimDirty, else FILL.
- If Miss is high and VictimWay is not one-hot, the request is accepted as given. Flagging the violation is the job of an assertion.
- WB:
  - BusReq = 1, BusWrite = 1.
  - BusAdr = latched VictimAdr base + beat*BEATW/8.
  - BusWData = latched line slice [beat*BEATW +: BEATW].
  - The beat advances only on BusAck. The counter wraps to 0 after beat BEATS-1, and the state moves to FILL.
- FILL:
  - BusReq = 1, BusWrite = 0.
  - BusAdr = miss line base + beat*BEATW/8.
  - On BusAck, BusRData is written into FillLine[beat*BEATW +: BEATW].
  - After the last beat the state moves to WRITE.
- WRITE:
  - Lasts one cycle. FillWrite, SetValid and LRUWriteEn are each 1 for this cycle.
  - FillWay holds the latched way.
  - Next state is DONE.
- DONE: Done = 1 for one cycle; next state is IDLE. A new Miss is accepted no earlier than the following cycle.
- BusReq stays continuously high from the first WB/FILL cycle through the last beat. It is 0 in WRITE and DONE.
- A BusAck received while BusReq = 0 is ignored.
- FlushStage after acceptance has no effect; a started bus transaction always completes.
- Minimum latency, clean victim with BusAck tied high: accept cycle, then BEATS FILL cycles, then WRITE, then DONE.
- Inputs changing after acceptance have no effect. VictimWay, VictimLine and the addresses are used only as latched.
- BusAdr arithmetic is done in PAWIDTH bits; overflow wraps.

Optional Feature:
- Macro: CACHE_CRITWORD_EN.
- Defined:
  - Fill starts at beat k = MissAdr[BYTEOFF-1:$clog2(BEATW/8)] and wraps modulo BEATS: k, k+1, ..., BEATS-1, 0, ..., k-1.
  - The beat BusRData lands in follows the same wrapped order.
  - An extra output, CritWordValid (1 bit), pulses for one cycle on the BusAck of beat k.
- Undefined: fill always starts at beat 0, and the CritWordValid port is absent.
- Writeback order is 0..BEATS-1 in both cases.

Test Plan:
- Clean miss, MissAdr=0x1000_0048, VictimWay=4'b0100, BusAck tied 1 -> 4 FILL beats at 0x1000_0040/48/50/58; FillLine = concatenated beats; FillWrite, SetValid and LRUWriteEn each pulse once with FillWay=4'b0100; Done 6 cycles after accept.
- Dirty victim, VictimAdr=0x2000_0000, VictimLine beats A,B,C,D -> 4 write beats at 0x2000_0000..0x2000_0018 with BusWData A..D, then 4 fill beats; BusWrite drops exactly at the first fill beat.
- BusAck stalls: hold BusAck=0 for 3 cycles before each beat -> BusAdr/BusWData held stable during the stalls; 4 beats total; no extra strobes.
- Miss together with FlushStage=1 in IDLE -> not accepted, Busy stays 0; FlushStage=1 after acceptance -> transaction completes normally.
- reset_n driven low during FILL beat 2 -> asynchronously BusReq=0 and Busy=0; no FillWrite; the next Miss restarts at beat 0.
- With CACHE_CRITWORD_EN, MissAdr offset 0x10 -> fill order beats 2,3,0,1; CritWordValid pulses on the first BusAck; FillLine is correctly placed.
